truth_table_sequencer: RTL and testbench

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

---
 rtl/tts_pkg.sv | 21 ++
 rtl/tts_settle_timer.sv | 37 +++
 rtl/truth_table_sequencer.sv | 165 ++++++++++++++++
 tb/tb_truth_table_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tts_pkg.sv
// Shared types and helpers for the truth-table sequencer.
// Optional checker is selected by the TTS_COMPARE_EN macro in the top file.
package tts_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } tts_state_e;

  // Settle counter width: covers SETTLE values 0..15
  localparam int TTS_SETTLE_W = 4;

  // Number of vectors (and table bits) for a given input count
  function automatic int tts_depth(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/tts_settle_timer.sv
// Load / count-down settle counter. expired_o is high once the count
// reaches zero, telling the sweep FSM the vector has been held long enough.
module tts_settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload on request, otherwise count down and stop at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: sweeps every input vector of a small combinational
// DUT in ascending binary order, holds each for SETTLE+1 cycles, and captures
// the DUT output into table_q. Defining TTS_COMPARE_EN adds a checker that
// counts differences against EXPECTED and reports pass at the end of a sweep;
// without it pass and mismatches are constant zero.
module truth_table_sequencer
  import tts_pkg::*;
#(
  parameter int                         N_IN     = 4,
  parameter int                         SETTLE   = 2,
  parameter logic [tts_depth(N_IN)-1:0] EXPECTED = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         dut_out,
  output logic [N_IN-1:0]              vec,
  output logic                         busy,
  output logic                         done,
  output logic [tts_depth(N_IN)-1:0]   table_q,
  output logic                         pass,
  output logic [N_IN:0]                mismatches
);

  localparam int DEPTH = tts_depth(N_IN);
  // DRIVE lasts SETTLE cycles; the timer reports expiry in the last of them
  localparam logic [TTS_SETTLE_W-1:0] LOAD_VAL =
      (SETTLE > 0) ? TTS_SETTLE_W'(SETTLE - 1) : '0;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(DEPTH - 1);
  // With no settle time each vector goes straight to sampling
  localparam tts_state_e FIRST_ST = (SETTLE == 0) ? SAMPLE : DRIVE;

  tts_state_e        state_q;
  logic [N_IN-1:0]   index_q;
  logic [N_IN-1:0]   vec_q;
  logic              busy_q;
  logic              done_q;
  logic [DEPTH-1:0]  tbl_q;
`ifdef TTS_COMPARE_EN
  logic              pass_q;
  logic [N_IN:0]     mism_q;
`endif

  logic tmr_load;
  logic tmr_expired;

  // Reload the settle timer on every edge that enters a fresh vector
  always_comb begin
    tmr_load = 1'b0;
    case (state_q)
      IDLE:    tmr_load = start && !abort;
      SAMPLE:  tmr_load = !abort && (index_q != LAST_IDX);
      default: tmr_load = 1'b0;
    endcase
  end

  tts_settle_timer #(
    .W(TTS_SETTLE_W)
  ) u_settle (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (LOAD_VAL),
    .expired_o  (tmr_expired)
  );

  // Sweep FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      index_q <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tbl_q   <= '0;
`ifdef TTS_COMPARE_EN
      pass_q  <= 1'b0;
      mism_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // abort wins over a simultaneous start
          if (start && !abort) begin
            state_q <= FIRST_ST;
            index_q <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b1;
            tbl_q   <= '0;
`ifdef TTS_COMPARE_EN
            pass_q  <= 1'b0;
            mism_q  <= '0;
`endif
          end
        end

        DRIVE: begin
          if (abort) begin
            state_q <= IDLE;
            index_q <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
          end else if (tmr_expired) begin
            state_q <= SAMPLE;
          end
        end

        SAMPLE: begin
          if (abort) begin
            // Aborted sample is not captured; earlier bits are kept
            state_q <= IDLE;
            index_q <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            tbl_q[index_q] <= dut_out;
`ifdef TTS_COMPARE_EN
            if (dut_out != EXPECTED[index_q]) begin
              mism_q <= mism_q + 1'b1;
            end
`endif
            if (index_q == LAST_IDX) begin
              state_q <= DONE;
              index_q <= '0;
              vec_q   <= '0;
              busy_q  <= 1'b0;
            end else begin
              state_q <= FIRST_ST;
              index_q <= index_q + 1'b1;
              vec_q   <= index_q + 1'b1;
            end
          end
        end

        DONE: begin
          // Final mismatch count is complete here; publish verdict with done
          state_q <= IDLE;
          done_q  <= 1'b1;
`ifdef TTS_COMPARE_EN
          pass_q  <= (mism_q == '0);
`endif
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign vec     = vec_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign table_q = tbl_q;
`ifdef TTS_COMPARE_EN
  assign pass       = pass_q;
  assign mismatches = mism_q;
`else
  assign pass       = 1'b0;
  assign mismatches = '0;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Self-checking bench: two sequencers (SETTLE=2 and SETTLE=0) each drive a
// truth-table DUT held in a bench variable. Expected vectors, done timing and
// captured tables are derived from sweep arithmetic and the DUT table itself.
module tb_truth_table_sequencer;

`ifdef TTS_COMPARE_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  localparam logic [15:0] EXP0 = 16'h8000;
  localparam logic [15:0] EXP1 = 16'h6997;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_r [2];
  logic abort_r [2];
  logic [15:0] tt_r [2];

  logic        dut_out_w [2];
  logic [3:0]  vec_w     [2];
  logic        busy_w    [2];
  logic        done_w    [2];
  logic [15:0] table_w   [2];
  logic        pass_w    [2];
  logic [4:0]  mism_w    [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign dut_out_w[0] = tt_r[0][vec_w[0]];
  assign dut_out_w[1] = tt_r[1][vec_w[1]];

  truth_table_sequencer #(.N_IN(4), .SETTLE(2), .EXPECTED(EXP0)) u0 (
    .clk(clk), .rst(rst), .start(start_r[0]), .abort(abort_r[0]),
    .dut_out(dut_out_w[0]), .vec(vec_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .table_q(table_w[0]), .pass(pass_w[0]), .mismatches(mism_w[0]));

  truth_table_sequencer #(.N_IN(4), .SETTLE(0), .EXPECTED(EXP1)) u1 (
    .clk(clk), .rst(rst), .start(start_r[1]), .abort(abort_r[1]),
    .dut_out(dut_out_w[1]), .vec(vec_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .table_q(table_w[1]), .pass(pass_w[1]), .mismatches(mism_w[1]));

  function automatic int settle_of(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  function automatic logic [15:0] exp_of(input int u);
    return (u == 0) ? EXP0 : EXP1;
  endfunction

  function automatic logic [4:0] exp_mism(input int u);
    return CMP ? 5'($countones(tt_r[u] ^ exp_of(u))) : 5'd0;
  endfunction

  function automatic logic exp_pass(input int u);
    return CMP ? ($countones(tt_r[u] ^ exp_of(u)) == 0) : 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sweep on unit u. Optional events (negative = unused) occur during
  // sweep cycle k and are sampled on the following edge.
  task automatic run_sweep(input int u, input int abort_at, input int restart_at,
                           input int rst_at, input string name);
    int p, t;
    logic [3:0] ev;
    logic [15:0] mask;
    bit seen_done;
    p = settle_of(u) + 1;
    t = 16 * p;
    start_r[u] = 1'b1;
    tick();
    start_r[u] = 1'b0;
    checks++;
    if (table_w[u] !== 16'h0 || mism_w[u] !== 5'd0 || pass_w[u] !== 1'b0) begin
      errors++;
      $display("FAIL %s start_clear table=%h mism=%0d pass=%b required 0000/0/0",
               name, table_w[u], mism_w[u], pass_w[u]);
    end
    for (int k = 0; k <= t + 2; k++) begin
      ev = (k < t) ? 4'(k / p) : 4'd0;
      checks++;
      if (vec_w[u] !== ev || busy_w[u] !== (k < t) || done_w[u] !== (k == t + 1)) begin
        errors++;
        $display("FAIL %s cycle %0d vec=%0d busy=%b done=%b required vec=%0d busy=%b done=%b",
                 name, k, vec_w[u], busy_w[u], done_w[u], ev, (k < t), (k == t + 1));
      end
      if (k == restart_at) start_r[u] = 1'b1;
      if (k == abort_at)   abort_r[u] = 1'b1;
      if (k == rst_at)     rst = 1'b1;
      tick();
      start_r[u] = 1'b0;
      if (k == abort_at) begin
        abort_r[u] = 1'b0;
        mask = '0;
        for (int i = 0; i < 16; i++) if ((i + 1) * p <= k) mask[i] = 1'b1;
        checks++;
        if (busy_w[u] !== 1'b0 || vec_w[u] !== 4'd0 || table_w[u] !== (tt_r[u] & mask)) begin
          errors++;
          $display("FAIL %s abort busy=%b vec=%0d table=%h required 0/0/%h",
                   name, busy_w[u], vec_w[u], table_w[u], tt_r[u] & mask);
        end
        seen_done = 1'b0;
        for (int j = 0; j < 6; j++) begin
          if (done_w[u] !== 1'b0 || busy_w[u] !== 1'b0) seen_done = 1'b1;
          tick();
        end
        checks++;
        if (seen_done) begin
          errors++;
          $display("FAIL %s abort_quiet done/busy seen=1 required 0", name);
        end
        return;
      end
      if (k == rst_at) begin
        rst = 1'b0;
        checks++;
        if (vec_w[u] !== 4'd0 || busy_w[u] !== 1'b0 || done_w[u] !== 1'b0 ||
            table_w[u] !== 16'h0 || pass_w[u] !== 1'b0 || mism_w[u] !== 5'd0) begin
          errors++;
          $display("FAIL %s reset vec=%0d busy=%b done=%b table=%h pass=%b mism=%0d required all 0",
                   name, vec_w[u], busy_w[u], done_w[u], table_w[u], pass_w[u], mism_w[u]);
        end
        return;
      end
    end
    checks++;
    if (table_w[u] !== tt_r[u] || mism_w[u] !== exp_mism(u) || pass_w[u] !== exp_pass(u)) begin
      errors++;
      $display("FAIL %s result table=%h mism=%0d pass=%b required %h/%0d/%b",
               name, table_w[u], mism_w[u], pass_w[u], tt_r[u], exp_mism(u), exp_pass(u));
    end
    $display("%s: unit %0d table=%h mism=%0d pass=%b", name, u, table_w[u], mism_w[u], pass_w[u]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (vec_w[u] !== 4'd0 || busy_w[u] !== 1'b0 || done_w[u] !== 1'b0 ||
          table_w[u] !== 16'h0 || pass_w[u] !== 1'b0 || mism_w[u] !== 5'd0) begin
        errors++;
        $display("FAIL reset_state unit %0d vec=%0d busy=%b done=%b table=%h required all 0",
                 u, vec_w[u], busy_w[u], done_w[u], table_w[u]);
      end
    end
    $display("test_reset: done");
  endtask

  task automatic test_known_tables();
    tt_r[0] = 16'h8000;
    run_sweep(0, -1, -1, -1, "and_settle2");
    tt_r[0] = 16'h6996;
    run_sweep(0, -1, -1, -1, "xor_settle2");
    tt_r[1] = 16'h6996;
    run_sweep(1, -1, -1, -1, "xor_settle0");
    tt_r[1] = 16'h8000;
    run_sweep(1, -1, -1, -1, "and_settle0");
  endtask

  task automatic test_random();
    int u;
    for (int n = 0; n < 6; n++) begin
      u = int'($urandom_range(0, 1));
      tt_r[u] = 16'($urandom);
      if (n == 5) tt_r[u] = exp_of(u);
      run_sweep(u, -1, -1, -1, "random");
    end
  endtask

  task automatic test_restart();
    tt_r[0] = 16'($urandom);
    run_sweep(0, -1, 5, -1, "restart_c5");
  endtask

  task automatic test_abort();
    tt_r[0] = 16'($urandom);
    run_sweep(0, 9, -1, -1, "abort_c10");
    run_sweep(0, -1, -1, -1, "after_abort");
    tt_r[1] = 16'($urandom);
    run_sweep(1, int'($urandom_range(0, 15)), -1, -1, "abort_rand");
    run_sweep(1, -1, -1, -1, "after_abort_rand");
  endtask

  task automatic test_start_abort_idle();
    logic [15:0] held;
    bit bad;
    held = table_w[1];
    start_r[1] = 1'b1;
    abort_r[1] = 1'b1;
    tick();
    start_r[1] = 1'b0;
    abort_r[1] = 1'b0;
    bad = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (busy_w[1] !== 1'b0 || vec_w[1] !== 4'd0 || done_w[1] !== 1'b0 || table_w[1] !== held)
        bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL start_abort_idle left idle or lost table=%h required idle, table %h",
               table_w[1], held);
    end
    $display("test_start_abort_idle: done");
  endtask

  task automatic test_reset_mid();
    tt_r[0] = 16'($urandom);
    run_sweep(0, -1, -1, 19, "reset_c20");
    run_sweep(0, -1, -1, -1, "after_reset");
  endtask

  task automatic test_hold();
    int w;
    w = int'($urandom_range(3, 12));
    for (int j = 0; j < w; j++) tick();
    checks++;
    if (table_w[0] !== tt_r[0] || mism_w[0] !== exp_mism(0) || pass_w[0] !== exp_pass(0)) begin
      errors++;
      $display("FAIL hold table=%h mism=%0d pass=%b required %h/%0d/%b",
               table_w[0], mism_w[0], pass_w[0], tt_r[0], exp_mism(0), exp_pass(0));
    end
    $display("test_hold: waited %0d cycles", w);
  endtask

  initial begin
    start_r[0] = 1'b0; start_r[1] = 1'b0;
    abort_r[0] = 1'b0; abort_r[1] = 1'b0;
    tt_r[0] = 16'h0;   tt_r[1] = 16'h0;
    test_reset();
    test_known_tables();
    test_random();
    test_restart();
    test_abort();
    test_start_abort_idle();
    test_reset_mid();
    test_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
